// File: rtl/sd_seq_pkg.sv
// Shared types and constants for the self-destruct sequencer.
// State codes are fixed because they are visible on the state output.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMING    = 3'd1,
    COUNTDOWN = 3'd2,
    DETONATED = 3'd3
  } sd_state_t;

  localparam logic [7:0] LED_OFF = 8'h00;
  localparam logic [7:0] LED_ARM = 8'h81;
  localparam logic [7:0] LED_ALL = 8'hFF;

endpackage

// File: rtl/sd_vote2of3.sv
// Purely combinational 2-of-3 majority over the debounced fault switches.
module sd_vote2of3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic vote
);

  assign vote = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/sd_sequencer.sv
// Self-destruct sequencer: idle -> arming -> LED countdown -> detonated lockout.
// Optional blinking countdown LEDs are enabled with the SD_SEQ_BLINK_EN macro.
module sd_sequencer
  import sd_seq_pkg::*;
#(
  parameter int TICKS_PER_STEP = 100,
  parameter int ARM_TICKS      = 3,
  parameter int BLINK_TICKS    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       combat,
  input  logic       danger,
  input  logic       damaged,
  input  logic       immobilized,
  output logic [7:0] leds,
  output logic [2:0] state,
  output logic       detonate
);

  localparam logic [9:0] STEP_LAST = 10'(TICKS_PER_STEP - 1);
  localparam logic [7:0] ARM_LAST  = 8'(ARM_TICKS);

  logic vote;
  logic qual;

  sd_state_t  state_reg, state_next;
  logic [7:0] arm_cnt_reg, arm_cnt_next;
  logic [9:0] step_cnt_reg, step_cnt_next;
  logic [7:0] pattern_reg, pattern_next;
  logic [7:0] leds_reg, leds_next;
  logic       detonate_reg, detonate_next;

  sd_vote2of3 u_vote (
    .a    (danger),
    .b    (damaged),
    .c    (immobilized),
    .vote (vote)
  );

  assign qual = vote & combat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      arm_cnt_reg  <= '0;
      step_cnt_reg <= '0;
      pattern_reg  <= LED_ALL;
      leds_reg     <= LED_OFF;
      detonate_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      arm_cnt_reg  <= arm_cnt_next;
      step_cnt_reg <= step_cnt_next;
      pattern_reg  <= pattern_next;
      leds_reg     <= leds_next;
      detonate_reg <= detonate_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    arm_cnt_next  = arm_cnt_reg;
    step_cnt_next = step_cnt_reg;
    pattern_next  = pattern_reg;
    case (state_reg)
      IDLE: begin
        arm_cnt_next  = '0;
        step_cnt_next = '0;
        pattern_next  = LED_ALL;
        if (qual && tick) begin
          if (ARM_TICKS == 1) begin
            state_next = COUNTDOWN;
          end else begin
            state_next   = ARMING;
            arm_cnt_next = 8'd1;
          end
        end
      end
      ARMING: begin
        if (!qual) begin
          state_next   = IDLE;
          arm_cnt_next = '0;
        end else if (tick) begin
          if (arm_cnt_reg + 8'd1 == ARM_LAST) begin
            state_next    = COUNTDOWN;
            arm_cnt_next  = '0;
            step_cnt_next = '0;
            pattern_next  = LED_ALL;
          end else begin
            arm_cnt_next = arm_cnt_reg + 8'd1;
          end
        end
      end
      COUNTDOWN: begin
        // Abort outranks any step tick, so the pattern never shifts on the abort cycle.
        if (!combat) begin
          state_next    = IDLE;
          step_cnt_next = '0;
          pattern_next  = LED_ALL;
        end else if (tick) begin
          if (step_cnt_reg == STEP_LAST) begin
            step_cnt_next = '0;
            pattern_next  = pattern_reg >> 1;
            if ((pattern_reg >> 1) == LED_OFF) begin
              state_next = DETONATED;
            end
          end else begin
            step_cnt_next = step_cnt_reg + 10'd1;
          end
        end
      end
      DETONATED: begin
        state_next = DETONATED;
      end
      default: begin
        state_next    = IDLE;
        arm_cnt_next  = '0;
        step_cnt_next = '0;
        pattern_next  = LED_ALL;
      end
    endcase
  end

`ifdef SD_SEQ_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  logic [7:0] blink_cnt_reg, blink_cnt_next;
  logic       phase_reg, phase_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else begin
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  // Blink timing only runs while staying in COUNTDOWN; any entry or exit restarts it.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    if (state_reg != COUNTDOWN || state_next != COUNTDOWN) begin
      blink_cnt_next = '0;
      phase_next     = 1'b0;
    end else if (tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        phase_next     = ~phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 8'd1;
      end
    end
  end

  logic [7:0] countdown_leds;
  assign countdown_leds = phase_next ? LED_OFF : pattern_next;
`else
  logic [7:0] countdown_leds;
  assign countdown_leds = pattern_next;
`endif

  // Outputs are computed from next-state values so they change on the same edge as state.
  always_comb begin
    leds_next     = LED_OFF;
    detonate_next = 1'b0;
    case (state_next)
      IDLE:      leds_next = LED_OFF;
      ARMING:    leds_next = LED_ARM;
      COUNTDOWN: leds_next = countdown_leds;
      DETONATED: begin
        leds_next     = LED_ALL;
        detonate_next = 1'b1;
      end
      default:   leds_next = LED_OFF;
    endcase
  end

  assign leds     = leds_reg;
  assign state    = state_reg;
  assign detonate = detonate_reg;

endmodule

// File: tb/tb_sd_sequencer.sv
// Self-checking bench for sd_sequencer: directed scenarios plus randomized
// stimulus, every cycle compared against a tick-counting reference model.
module tb_sd_sequencer;

  localparam int TPS = 4;
  localparam int ARM = 3;
  localparam int BT  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       combat = 1'b0;
  logic       danger = 1'b0;
  logic       damaged = 1'b0;
  logic       immobilized = 1'b0;
  logic [7:0] leds;
  logic [2:0] dut_state;
  logic       detonate;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: phase 0..3, qualifying ticks seen, ticks spent in countdown.
  int m_state = 0;
  int m_arm = 0;
  int m_cd = 0;

  sd_sequencer #(
    .TICKS_PER_STEP (TPS),
    .ARM_TICKS      (ARM),
    .BLINK_TICKS    (BT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .combat      (combat),
    .danger      (danger),
    .damaged     (damaged),
    .immobilized (immobilized),
    .leds        (leds),
    .state       (dut_state),
    .detonate    (detonate)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_leds();
    logic [7:0] pat;
    case (m_state)
      1: return 8'h81;
      2: begin
        pat = 8'hFF >> (m_cd / TPS);
`ifdef SD_SEQ_BLINK_EN
        if (((m_cd / BT) % 2) == 1) pat = 8'h00;
`endif
        return pat;
      end
      3: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic step_model();
    int faults;
    bit q;
    faults = int'(danger) + int'(damaged) + int'(immobilized);
    q = combat && (faults >= 2);
    if (reset) begin
      m_state = 0; m_arm = 0; m_cd = 0;
    end else begin
      case (m_state)
        0: if (q && tick) begin
          m_arm = 1;
          if (m_arm >= ARM) begin m_state = 2; m_cd = 0; end
          else m_state = 1;
        end
        1: if (!q) begin
          m_state = 0; m_arm = 0;
        end else if (tick) begin
          m_arm++;
          if (m_arm == ARM) begin m_state = 2; m_cd = 0; end
        end
        2: if (!combat) begin
          m_state = 0; m_cd = 0;
        end else if (tick) begin
          m_cd++;
          if (m_cd == 8 * TPS) m_state = 3;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    step_model();
    check_eq("state", {5'b0, dut_state}, 8'(m_state));
    check_eq("leds", leds, model_leds());
    check_eq("detonate", {7'b0, detonate}, {7'b0, (m_state == 3)});
  endtask

  task automatic set_in(input bit c, input bit d, input bit g, input bit i);
    combat = c; danger = d; damaged = g; immobilized = i;
  endtask

  initial begin
    bit found;

    // Reset with all inputs high, then release into arming and full countdown.
    reset = 1'b1; tick = 1'b1;
    set_in(1, 1, 1, 1);
    repeat (2) cycle();
    $display("reset held: state=%0d leds=%h detonate=%b", dut_state, leds, detonate);
    reset = 1'b0;
    cycle();
    check_eq("arm_after_reset", {5'b0, dut_state}, 8'd1);
    set_in(1, 1, 1, 0);
    repeat (45) cycle();
    check_eq("detonated", {5'b0, dut_state}, 8'd3);
    $display("countdown run: state=%0d leds=%h detonate=%b", dut_state, leds, detonate);

    // Lockout: random input activity in DETONATED changes nothing.
    for (int k = 0; k < 20; k++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick = 1'($urandom);
      cycle();
    end
    tick = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_in(0, 0, 0, 0);
    cycle();
    $display("lockout then reset: state=%0d leds=%h", dut_state, leds);

    // Single fault never qualifies.
    set_in(1, 1, 0, 0);
    repeat (100) cycle();
    check_eq("single_fault_idle", {5'b0, dut_state}, 8'd0);
    $display("single fault: state=%0d leds=%h", dut_state, leds);

    // Vote lost after two qualifying ticks restarts the arming count.
    set_in(1, 1, 1, 0);
    repeat (2) cycle();
    set_in(1, 1, 0, 0);
    cycle();
    check_eq("vote_drop_idle", {5'b0, dut_state}, 8'd0);
    set_in(1, 0, 1, 1);
    repeat (2) cycle();
    check_eq("rearm_still_arming", {5'b0, dut_state}, 8'd1);
    cycle();
    check_eq("rearm_countdown", {5'b0, dut_state}, 8'd2);
    $display("vote drop/rearm: state=%0d leds=%h", dut_state, leds);

    // Abort at pattern 1F exactly on a step tick: no shift, then FF on restart.
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_state == 2 && (m_cd / TPS) == 3 && (m_cd % TPS) == TPS - 1) found = 1'b1;
      else cycle();
    end
    check_eq("reached_1f", {7'b0, found}, 8'd1);
    combat = 1'b0;
    cycle();
    check_eq("abort_leds", leds, 8'h00);
    set_in(1, 1, 1, 1);
    repeat (8) cycle();
    $display("abort on step tick: state=%0d leds=%h", dut_state, leds);

    // Randomized traffic with sporadic ticks and resets.
    for (int k = 0; k < 2000; k++) begin
      reset = ($urandom_range(199, 0) == 0);
      tick  = ($urandom_range(3, 0) != 0);
      set_in($urandom_range(19, 0) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
    end
    reset = 1'b0;
    $display("random phase: %0d cycles total", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_sequencer.md
# sd_sequencer

Controller for the robot self-destruct chain. It takes the debounced status switches and the 10 ms tick, and runs a registered state machine: idle, arming, LED countdown, detonation. It drives the 8-LED bank and the terminal detonate flag. It sits between the debouncers and the LED pins, and replaces the free-running voter/counter/display glue with one sequenced, resettable controller.

## Interface
Parameters:
- TICKS_PER_STEP, 100: ticks per countdown step, i.e. per LED shift. Range 1..1023.
- ARM_TICKS, 3: consecutive qualifying ticks needed to leave ARMING. Range 1..255.
- BLINK_TICKS, 33: ticks per blink half-period. Used only with SD_SEQ_BLINK_EN.

Ports:
- clk, in, 1: single system clock.
- reset, in, 1: synchronous, active-high. Overrides everything.
- tick, in, 1: one-clk strobe every 10 ms. All counters advance only on tick=1.
- combat, in, 1: debounced in-combat switch. Enables the sequence; dropping it aborts.
- danger, damaged, immobilized, in, 1 each: debounced fault switches.
- leds, out, 8: LED bank, registered.
- state, out, 3: current state code, registered.
- detonate, out, 1: high only in DETONATED, registered.

## Operation
- vote = any 2 of {danger, damaged, immobilized}. It is combinational and sampled in the FSM.
- qual = vote && combat.
- States (codes):
  - IDLE: 0
  - ARMING: 1
  - COUNTDOWN: 2
  - DETONATED: 3
  - Codes 4..7 are unused and recover to IDLE.
- IDLE:
  - leds=8'h00.
  - If qual && tick: go to ARMING with arm_cnt=1.
  - If ARM_TICKS==1: go directly to COUNTDOWN.
- ARMING:
  - leds=8'h81.
  - If !qual (any cycle): go to IDLE and clear arm_cnt.
  - Else on tick: arm_cnt++. When arm_cnt reaches ARM_TICKS, go to COUNTDOWN with pattern=8'hFF and step_cnt=0.
- COUNTDOWN:
  - leds=pattern.
  - If !combat: go to IDLE (abort), and reload pattern=8'hFF.
  - Loss of vote alone does not abort.
  - On tick: step_cnt++. At step_cnt==TICKS_PER_STEP-1, do pattern<=pattern>>1 (logical shift, zero fill) and step_cnt<=0.
  - When the shifted value is 8'h00: go to DETONATED on the same edge.
- DETONATED:
  - leds=8'hFF steady, detonate=1.
  - Terminal lockout: every input is ignored until reset.
- Priority, highest first: reset > abort (combat low) > shift/transition.
  - Abort on the same cycle as the final shift: go to IDLE, no detonation.
  - Abort on the same cycle as a step tick: the pattern is not shifted.
- Reset values: state=IDLE, leds=8'h00, detonate=0, all counters 0, pattern=8'hFF.

## Timing
- Every output is a register. There is no combinational path from input to output.
- Transitions take effect on the clk edge where the condition is sampled. Outputs reflect the new state one cycle later, at the same edge as the state register.
- COUNTDOWN duration is 8 × TICKS_PER_STEP ticks from entry to detonation. With the defaults that is 8 s.
- Counter widths:
  - step_cnt: 10 bits.
  - arm_cnt: 8 bits.
  - blink_cnt: 8 bits.
  - No counter wraps. Each one is cleared at its terminal count or when the state changes.
- Reset mid-countdown: IDLE on the next edge, with all state cleared.

## Configuration
- SD_SEQ_BLINK_EN defined:
  - In COUNTDOWN, blink_cnt counts ticks. Every BLINK_TICKS ticks, phase toggles.
  - leds = phase ? 8'h00 : pattern.
  - phase=0 on COUNTDOWN entry.
  - Other states are unaffected.
- Not defined: leds=pattern steady. blink_cnt and phase are not synthesised.

## Structure
- Package sd_seq_pkg holds:
  - The state enum (IDLE, ARMING, COUNTDOWN, DETONATED).
  - LED constants: LED_OFF=8'h00, LED_ARM=8'h81, LED_ALL=8'hFF.
- One sub-module, sd_vote2of3: registered-free 2-of-3 majority.
- The FSM, counters and LED mux stay in sd_sequencer.

## Test plan
Bench parameters: TICKS_PER_STEP=4, ARM_TICKS=3, BLINK_TICKS=2, tick=1 every cycle.
1. Reset with all inputs high → state=0, leds=00, detonate=0. Releasing reset then gives ARMING on the next edge.
2. combat=danger=damaged=1 → ARMING with leds=81. Three ticks later, COUNTDOWN with leds=FF. leds then read 7F, 3F, … at 4-tick intervals. After 32 countdown ticks: state=3, leds=FF, detonate=1.
3. combat=1, danger=1 only → stays in IDLE, leds=00, for 100 cycles.
4. Drop vote after 2 ARMING ticks → IDLE. Re-assert the vote → three full ticks are needed again before COUNTDOWN.
5. Drop combat at leds=1F on the same cycle as a step tick → IDLE, leds=00, no 0F ever seen. Restarting reloads FF.
6. In DETONATED, toggle all inputs → no change. Assert reset → IDLE. With SD_SEQ_BLINK_EN, the COUNTDOWN leds alternate FF/00 every 2 ticks.
